ifetch_dmem_arbiter: RTL and testbench
======================================

# ifetch_dmem_arbiter

Sequencer and arbiter that shares one single-port unified memory bus between instruction fetch (IF) and the data-memory stage (MEM) of the 5-stage MIPS pipeline. It serialises the two accesses of each pipeline step, with data first. It holds a global `stall` that freezes every pipeline register, including Exe/Mem, until both accesses are complete. It then releases the pipeline for exactly one cycle. A watchdog abandons hung bus transactions so the core cannot deadlock.

## Interface
- `data_size`, 32, width of addresses, instructions and data words
- `TIMEOUT`, 1023, bus cycles to wait for `bus_ready` before abandoning (1..65535)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low
- `if_req`  in  1  IF needs an instruction this step
- `if_addr`  in  data_size  PC for the fetch
- `mem_rd`  in  1  MEM-stage load (MemtoRegM)
- `mem_wr`  in  1  MEM-stage store (MemWriteM)
- `mem_addr`  in  data_size  data address (ALUOutM)
- `mem_wdata`  in  data_size  store data (WriteDataM)
- `stall`  out  1  1 = all pipeline registers hold this cycle
- `instr`  out  data_size  fetched instruction, registered
- `rdata`  out  data_size  load data, registered
- `bus_req`  out  1  bus transaction active
- `bus_we`  out  1  write transaction
- `bus_addr`  out  data_size  bus address
- `bus_wdata`  out  data_size  bus write data
- `bus_rdata`  in  data_size  bus read data, valid with `bus_ready`
- `bus_ready`  in  1  transaction completes this cycle
- `bus_err`  out  1  sticky flag: a watchdog timeout has occurred

## Operation
- States: IDLE, DATA, FETCH. Per-step flags: `d_done`, `f_done`.
- Needs: `need_d = mem_rd | mem_wr`, `need_f = if_req`.
- IDLE: `stall = (need_d & !d_done) | (need_f & !f_done)`.
  - Next state is DATA if `need_d & !d_done`, else FETCH if `need_f & !f_done`, else stay in IDLE.
  - When `stall=0` the pipeline advances on that edge, and `d_done` and `f_done` clear.
- DATA: `bus_req=1`, `bus_we=mem_wr`, `bus_addr=mem_addr`, `bus_wdata=mem_wdata`, `stall=1`.
  - On `bus_ready`, `rdata<=bus_rdata` if this is a read, and `d_done<=1`.
  - Next state is FETCH if `need_f`, else IDLE.
- FETCH: `bus_req=1`, `bus_we=0`, `bus_addr=if_addr`, `stall=1`.
  - On `bus_ready`, `instr<=bus_rdata` and `f_done<=1`; next state is IDLE.
- Priority: data always precedes fetch, because MEM holds the older instruction.
- `mem_rd & mem_wr` together: treated as a write and `rdata` is unchanged.
- Outside DATA/FETCH: `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wdata=0`.
- Watchdog: a 16-bit counter clears on each entry to DATA/FETCH and increments every cycle `bus_req & !bus_ready`.
  - When it reaches `TIMEOUT`, the access is abandoned as if completed.
  - An abandoned fetch writes 0 to `instr` (a NOP, sll $0,$0,0). An abandoned load writes 0 to `rdata`. An abandoned store is dropped.
  - `bus_err<=1`; it clears only on reset.
- Inputs are stable while `stall=1` because the pipeline is frozen; the block does not latch them.

## Timing
- Reset (async, `reset=0`): state IDLE, flags 0, `instr=0`, `rdata=0`, `bus_err=0`, counter 0. `bus_req`, `bus_we` and `bus_addr` drop to 0 immediately.
- Reset mid-transaction abandons the access with no completion. After release, `stall` reflects the current needs in IDLE.
- Zero-wait bus (`bus_ready` in the first bus cycle):
  - Fetch only: `stall` is 1,1,0, so 3 cycles per step.
  - Load/store plus fetch: `stall` is 1,1,1,0, so 4 cycles.
  - No needs: `stall=0` every cycle.
- Each wait state on the bus adds one cycle.
- `instr` and `rdata` update on the `bus_ready` edge and hold until the next completion of the same kind.
- A `bus_ready` arriving outside DATA/FETCH is ignored.
- Timeout and `bus_ready` in the same cycle: `bus_ready` wins, the data is captured and `bus_err` is not set.
- `stall` is combinational from state, flags and needs. It never pulses to 0 while an access is outstanding.

## Test plan
- Fetch only, zero-wait (`if_req=1`, `if_addr=0x40`, `bus_rdata=0x2010_0005` with ready):
  - `bus_addr=0x40`, `bus_we=0`.
  - `instr=0x2010_0005`.
  - `stall` pattern 1,1,0, repeating each step.
- Load plus fetch (`mem_rd=1`, `mem_addr=0x100`, `if_addr=0x44`):
  - Bus order is 0x100 then 0x44.
  - `rdata` then `instr` captured.
  - `stall` 1,1,1,0.
- Store with 2 wait states (`mem_wr=1`, `mem_addr=0x200`, `mem_wdata=0xDEAD_BEEF`):
  - `bus_we=1` held for 3 cycles with the data stable.
  - `rdata` unchanged; fetch follows.
- Hung bus (`TIMEOUT=4`, `bus_ready` never asserted during FETCH):
  - Abandoned after 4 wait cycles.
  - `instr=0`, `bus_err=1` and sticky; the pipeline advances.
- Reset asserted mid-DATA:
  - `bus_req=0` immediately; outputs at reset values.
  - After release with `mem_rd=1`, the access restarts from IDLE.
- `mem_rd=1` and `mem_wr=1` together: a single write transaction; `rdata` holds its prior value.

Source files
------------

// File: rtl/ifetch_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// ifetch_dmem_arbiter
//
// Shares one single-port unified memory bus between instruction fetch (IF)
// and the MEM stage of the 5-stage pipeline. Each pipeline step runs the
// data access first, because MEM holds the older instruction, and the fetch
// second. A global stall freezes every pipeline register until both accesses
// are finished. The pipeline is then released for exactly one cycle.
//
// A watchdog abandons a bus transaction that never sees bus_ready, so a hung
// bus cannot deadlock the core. The abandon result depends on the access:
//   - fetch: returns a NOP (0)
//   - load:  returns 0
//   - store: dropped
// Any abandon sets the sticky bus_err flag.
//
// Ports
//   clk, reset       clock, asynchronous active-low reset
//   if_req, if_addr  fetch request for this step and its PC
//   mem_rd, mem_wr   MEM-stage load / store; both set is treated as a store
//   mem_addr         data address
//   mem_wdata        store data
//   stall            1 = all pipeline registers hold this cycle
//   instr, rdata     registered fetch / load results
//   bus_req, bus_we  bus transaction active / write transaction
//   bus_addr         bus address (0 when idle)
//   bus_wdata        bus write data (0 when idle)
//   bus_rdata        bus read data, valid with bus_ready
//   bus_ready        current transaction completes this cycle
//   bus_err          sticky: a watchdog timeout has occurred
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no bus activity; decides what the current step still needs
// DATA  | load/store transaction on the bus
// FETCH | instruction fetch transaction on the bus
// ---------------------------------------------------------------------------
module ifetch_dmem_arbiter #(
  parameter int data_size = 32,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [data_size-1:0] if_addr,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [data_size-1:0] mem_addr,
  input  logic [data_size-1:0] mem_wdata,
  output logic                 stall,
  output logic [data_size-1:0] instr,
  output logic [data_size-1:0] rdata,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [data_size-1:0] bus_addr,
  output logic [data_size-1:0] bus_wdata,
  input  logic [data_size-1:0] bus_rdata,
  input  logic                 bus_ready,
  output logic                 bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state;
  logic        d_done;
  logic        f_done;
  logic [15:0] wd_cnt;

  logic need_d;
  logic need_f;
  logic is_read;
  logic pend_d;
  logic pend_f;
  logic on_bus;
  logic timeout;
  logic finish;

  assign need_d  = mem_rd | mem_wr;
  assign need_f  = if_req;
  // A simultaneous load and store behaves as a store; rdata is left alone.
  assign is_read = mem_rd & ~mem_wr;
  assign pend_d  = need_d & ~d_done;
  assign pend_f  = need_f & ~f_done;

  assign on_bus  = (state == DATA) || (state == FETCH);
  // The timeout cycle still accepts bus_ready: a late ready beats the watchdog.
  assign timeout = on_bus && (wd_cnt == TIMEOUT_CNT);
  assign finish  = bus_ready | timeout;

  // Bus and stall decode. The bus outputs follow the state register, so they
  // drop the moment reset is asserted.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    stall     = pend_d | pend_f;
    case (state)
      DATA: begin
        bus_req   = 1'b1;
        bus_we    = mem_wr;
        bus_addr  = mem_addr;
        bus_wdata = mem_wdata;
        stall     = 1'b1;
      end
      FETCH: begin
        bus_req   = 1'b1;
        bus_addr  = if_addr;
        stall     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      d_done  <= 1'b0;
      f_done  <= 1'b0;
      wd_cnt  <= '0;
      instr   <= '0;
      rdata   <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // With stall low the pipeline advances on this edge, so a new
          // step starts with both flags clear.
          if (!stall) begin
            d_done <= 1'b0;
            f_done <= 1'b0;
          end
          if (pend_d) begin
            state  <= DATA;
            wd_cnt <= '0;
          end else if (pend_f) begin
            state  <= FETCH;
            wd_cnt <= '0;
          end
        end

        DATA: begin
          if (finish) begin
            if (bus_ready) begin
              if (is_read) rdata <= bus_rdata;
            end else begin
              // Abandoned: a load reads as 0 and a store is simply dropped.
              if (is_read) rdata <= '0;
              bus_err <= 1'b1;
            end
            d_done <= 1'b1;
            wd_cnt <= '0;
            state  <= pend_f ? FETCH : IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end

        FETCH: begin
          if (finish) begin
            if (bus_ready) begin
              instr <= bus_rdata;
            end else begin
              // Abandoned fetch turns into a NOP (sll $0,$0,0).
              instr   <= '0;
              bus_err <= 1'b1;
            end
            f_done <= 1'b1;
            wd_cnt <= '0;
            state  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ifetch_dmem_arbiter
//
// Drives whole pipeline steps and plays the bus. For each step the expected
// cycle timeline comes from the access rules:
//   - one IDLE cycle
//   - the data access, lasting min(wait, TIMEOUT)+1 cycles
//   - the fetch, lasting min(wait, TIMEOUT)+1 cycles
//   - a final release cycle
// Each cycle's stall and bus outputs are compared against that timeline.
// The instr/rdata/bus_err results are kept in a small result model.
// ---------------------------------------------------------------------------
module tb_ifetch_dmem_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_instr;
  logic [31:0] m_rdata;
  logic        m_err;

  ifetch_dmem_arbiter #(.data_size(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .instr     (instr),
    .rdata     (rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, ".instr"}, instr, m_instr);
    check({tag, ".rdata"}, rdata, m_rdata);
    check({tag, ".bus_err"}, 32'(bus_err), 32'(m_err));
  endtask

  // One pipeline step. wd/wf = wait states before bus_ready for the data
  // access and the fetch; anything above TO never completes on its own.
  task automatic run_step(input string tag,
                          input bit rd, input bit wr, input bit f,
                          input int wd, input int wf,
                          input logic [31:0] daddr, input logic [31:0] wdata,
                          input logic [31:0] drdata,
                          input logic [31:0] faddr, input logic [31:0] frdata);
    bit d;
    int dlen;
    int flen;
    int n;
    bit in_d;
    bit in_f;
    logic [31:0] e_addr;
    d    = rd | wr;
    dlen = d ? (((wd <= TO) ? wd : TO) + 1) : 0;
    flen = f ? (((wf <= TO) ? wf : TO) + 1) : 0;
    n    = (d || f) ? (dlen + flen + 2) : 1;

    mem_rd    = rd;
    mem_wr    = wr;
    mem_addr  = daddr;
    mem_wdata = wdata;
    if_req    = f;
    if_addr   = faddr;

    for (int c = 0; c < n; c++) begin
      in_d = d && (c >= 1) && (c < 1 + dlen);
      in_f = f && (c >= 1 + dlen) && (c < 1 + dlen + flen);
      if (in_d) begin
        bus_ready = ((c - 1) == wd);
        bus_rdata = drdata;
      end else if (in_f) begin
        bus_ready = ((c - 1 - dlen) == wf);
        bus_rdata = frdata;
      end else begin
        // Stray bus_ready while no access is outstanding must be ignored.
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      #1;
      check({tag, ".stall"},   32'(stall),   32'(c != n - 1));
      check({tag, ".bus_req"}, 32'(bus_req), 32'(in_d | in_f));
      check({tag, ".bus_we"},  32'(bus_we),  32'(in_d & wr));
      e_addr = in_d ? daddr : (in_f ? faddr : 32'h0);
      check({tag, ".bus_addr"}, bus_addr, e_addr);
      if (!in_f)
        check({tag, ".bus_wdata"}, bus_wdata, in_d ? wdata : 32'h0);
      @(posedge clk);
      #1;
    end
    bus_ready = 1'b0;

    if (d) begin
      if (wd > TO) m_err = 1'b1;
      if (!wr) m_rdata = (wd <= TO) ? drdata : 32'h0;
    end
    if (f) begin
      if (wf > TO) m_err = 1'b1;
      m_instr = (wf <= TO) ? frdata : 32'h0;
    end
    check_results(tag);
  endtask

  task automatic random_step(input string tag);
    bit rd;
    bit wr;
    bit f;
    rd = ($urandom_range(0, 2) == 0);
    wr = ($urandom_range(0, 3) == 0);
    f  = ($urandom_range(0, 4) != 0);
    run_step(tag, rd, wr, f,
             int'($urandom_range(0, TO + 2)), int'($urandom_range(0, TO + 2)),
             {$urandom_range(0, 255), 2'b00}, $urandom, $urandom,
             {$urandom_range(256, 511), 2'b00}, $urandom);
  endtask

  initial begin
    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    bus_rdata = '0;
    bus_ready = 1'b0;
    m_instr   = '0;
    m_rdata   = '0;
    m_err     = 1'b0;

    #1;
    check("reset.stall", 32'(stall), 32'h0);
    check("reset.bus_req", 32'(bus_req), 32'h0);
    check("reset.bus_addr", bus_addr, 32'h0);
    check_results("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Fetch only, zero wait, twice to see the pattern repeat.
    run_step("fetch0", 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h2010_0005);
    run_step("fetch1", 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h2010_0005);
    // Load plus fetch, zero wait.
    run_step("ld_f", 1, 0, 1, 0, 0, 32'h100, 32'h0, 32'h1234_5678, 32'h44, 32'h8C08_0000);
    // Store with two wait states, fetch follows.
    run_step("st_f", 0, 1, 1, 2, 0, 32'h200, 32'hDEAD_BEEF, 32'h5555_5555, 32'h48, 32'hAC09_0004);
    // No needs: stall stays low.
    run_step("none0", 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    run_step("none1", 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    // Load and store together: one write, rdata holds.
    run_step("rdwr", 1, 1, 1, 1, 1, 32'h208, 32'hCAFE_F00D, 32'h9999_9999, 32'h4C, 32'h0000_0020);
    // Ready in the very cycle the watchdog expires: data captured, no error.
    run_step("edge", 1, 0, 1, TO, TO, 32'h10C, 32'h0, 32'hA5A5_0001, 32'h50, 32'h1111_2222);
    // Hung fetch: abandoned, NOP returned, bus_err set.
    run_step("hung", 0, 0, 1, 0, 100, 32'h0, 32'h0, 32'h0, 32'h54, 32'hFFFF_FFFF);
    // bus_err stays set through a clean step.
    run_step("sticky", 1, 0, 1, 0, 1, 32'h110, 32'h0, 32'h0BAD_0001, 32'h58, 32'h2402_0001);

    for (int i = 0; i < 150; i++) random_step("rand");

    // Reset in the middle of a load.
    mem_rd    = 1'b1;
    mem_wr    = 1'b0;
    mem_addr  = 32'h300;
    if_req    = 1'b1;
    if_addr   = 32'h60;
    bus_ready = 1'b0;
    #1;
    check("mid.stall", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    check("mid.bus_req", 32'(bus_req), 32'h1);
    check("mid.bus_addr", bus_addr, 32'h300);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    m_instr = '0;
    m_rdata = '0;
    m_err   = 1'b0;
    check("rst.bus_req", 32'(bus_req), 32'h0);
    check("rst.bus_we", 32'(bus_we), 32'h0);
    check("rst.bus_addr", bus_addr, 32'h0);
    check("rst.stall", 32'(stall), 32'h1);
    check_results("rst");
    #1;
    reset = 1'b1;
    run_step("restart", 1, 0, 0, 1, 0, 32'h300, 32'h0, 32'h7777_0300, 32'h0, 32'h0);

    for (int i = 0; i < 30; i++) random_step("rand2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
